// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: memory access codes and FSM states.
package mips_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] ACCESS_WORD    = 2'b00;
  localparam logic [1:0] ACCESS_BURST4  = 2'b01;
  localparam logic [1:0] ACCESS_BURST8  = 2'b10;
  localparam logic [1:0] ACCESS_BURST16 = 2'b11;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus: memory burst port, redirect input and decode valid/ready stream.
interface mips_fetch_unit_if;
  import mips_fetch_unit_pkg::*;

  word_t      mem_addr;
  logic       mem_enable;
  logic       mem_rw;
  logic [1:0] mem_access_size;
  word_t      mem_dout;
  logic       mem_busy;
  logic       redirect;
  word_t      redirect_pc;
  logic       inst_valid;
  word_t      inst;
  word_t      inst_pc;
  logic       inst_ready;

  modport master (
    output mem_addr, mem_enable, mem_rw, mem_access_size, inst_valid, inst, inst_pc,
    input  mem_dout, mem_busy, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_addr, mem_enable, mem_rw, mem_access_size, inst_valid, inst, inst_pc,
    output mem_dout, mem_busy, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/mips_fetch_unit_fifo.sv
// Synchronous instruction buffer of {pc,inst} entries with flush and occupancy count.
module mips_fetch_unit_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wdata;
  end

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign valid = (count != '0);
  assign rdata = valid ? mem_q[rd_ptr] : '0;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: 8-word read bursts from fetch_pc into a 16-entry buffer for decode.
// Optional FETCH_STATS_EN adds burst/redirect/stall counters.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h8002_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          BURST_LEN  = 8
) (
  input  logic                    clk,
  input  logic                    rst_b,
  mips_fetch_unit_if.master       bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]             stat_bursts,
  output logic [31:0]             stat_redirects,
  output logic [31:0]             stat_stall_cycles
`endif
);

  localparam int          BEAT_W      = $clog2(BURST_LEN);
  localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH - BURST_LEN);

  fetch_state_t      state;
  word_t             fetch_pc;
  word_t             mem_addr_q;
  logic              mem_enable_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] skip_beats;
  logic              stale;
  logic              rtn_vld_p1;
  logic [BEAT_W-1:0] rtn_beat_p1;
  word_t             rtn_pc;
  logic              start_burst;
  logic              push;
  logic              pop;
  logic [63:0]       fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;

  // Credit: the buffer must have room for a whole burst; no words are in flight in IDLE.
  assign start_burst = (state == ST_IDLE) & ~bus.mem_busy & ~bus.redirect &
                       (fifo_count <= CREDIT_MAX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= START_ADDR;
      fetch_pc     <= START_ADDR;
      beat_cnt     <= '0;
      skip_beats   <= '0;
      stale        <= 1'b0;
      rtn_vld_p1   <= 1'b0;
    end else begin
      rtn_vld_p1 <= mem_enable_q;
      if (bus.redirect) fetch_pc <= bus.redirect_pc & ~32'h3;
      unique case (state)
        ST_IDLE: begin
          if (start_burst) begin
            state        <= ST_REQ;
            mem_enable_q <= 1'b1;
            mem_addr_q   <= fetch_pc & ~(BURST_BYTES - 32'd1);
            skip_beats   <= BEAT_W'((fetch_pc & (BURST_BYTES - 32'd1)) >> 2);
            beat_cnt     <= '0;
          end
        end
        ST_REQ: begin
          beat_cnt <= beat_cnt + 1'b1;
          if (bus.redirect) stale <= 1'b1;
          if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
            state        <= ST_WAIT;
            mem_enable_q <= 1'b0;
            // A redirected burst must not overwrite the redirect target.
            if (!stale && !bus.redirect) fetch_pc <= mem_addr_q + BURST_BYTES;
          end
        end
        ST_WAIT: begin
          if (!bus.mem_busy) begin
            state <= ST_IDLE;
            stale <= 1'b0;
          end else if (bus.redirect) begin
            stale <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Return stage: word for beat k arrives one cycle after its enable.
  always_ff @(posedge clk) begin
    rtn_beat_p1 <= beat_cnt;
  end

  assign rtn_pc = mem_addr_q | (32'(rtn_beat_p1) << 2);
  assign push   = rtn_vld_p1 & ~stale & ~bus.redirect & (rtn_beat_p1 >= skip_beats);
  assign pop    = fifo_valid & bus.inst_ready;

  mips_fetch_unit_fifo #(
    .DATA_W (64),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .flush (bus.redirect),
    .push  (push),
    .wdata ({rtn_pc, bus.mem_dout}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .valid (fifo_valid)
  );

  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_enable      = mem_enable_q;
  assign bus.mem_rw          = MEM_READ;
  assign bus.mem_access_size = ACCESS_BURST8;
  assign bus.inst_valid      = fifo_valid;
  assign bus.inst_pc         = fifo_rdata[63:32];
  assign bus.inst            = fifo_rdata[31:0];

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_bursts       <= '0;
      stat_redirects    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (start_burst)                   stat_bursts       <= stat_bursts + 32'd1;
      if (bus.redirect)                  stat_redirects    <= stat_redirects + 32'd1;
      if (bus.inst_ready && !fifo_valid) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
